// File: rtl/multififo_reader_pkg.sv
// Shared types and width helpers for the multififo_reader drain engine.
// The build option MULTIFIFO_READER_REFILL_EN is consumed in multififo_reader.sv.
package multififo_reader_pkg;

  typedef enum logic {
    LOAD  = 1'b0,
    DRAIN = 1'b1
  } multififo_reader_state_t;

  // Staged-entry count needs to represent PORT_NUM itself.
  function automatic int cnt_width(input int port_num);
    return $clog2(port_num) + 1;
  endfunction

  function automatic int idx_width(input int port_num);
    return (port_num > 1) ? $clog2(port_num) : 1;
  endfunction

endpackage

// File: rtl/multififo_reader_prims.sv
// Shared combinational primitives: count_one (optionally leading-run only) and
// expand_one (count to thermometer mask), used by multififo_reader.
module count_one #(
  parameter int WIDTH      = 2,
  parameter bit CONTINUOUS = 1'b1
) (
  input  logic [WIDTH-1:0]       data,
  output logic [$clog2(WIDTH):0] count
);

  logic run_s;

  always_comb begin
    count = '0;
    run_s = 1'b1;
    for (int i = 0; i < WIDTH; i++) begin
      if (data[i] && (run_s || !CONTINUOUS)) begin
        count = count + 1'b1;
      end else begin
        run_s = 1'b0;
      end
    end
  end

endmodule

module expand_one #(
  parameter int WIDTH = 2
) (
  input  logic [$clog2(WIDTH):0] count,
  output logic [WIDTH-1:0]       mask
);

  always_comb begin
    mask = '0;
    for (int i = 0; i < WIDTH; i++) begin
      mask[i] = (int'(count) > i);
    end
  end

endmodule

// File: rtl/multififo_reader.sv
// Pops a batch of up to PORT_NUM FIFO entries and streams them out one per cycle.
// Define MULTIFIFO_READER_REFILL_EN to reload on the last acceptance (no bubble).
module multififo_reader
  import multififo_reader_pkg::*;
#(
  parameter int PORT_NUM = 2,
  parameter int WIDTH    = 32
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                flush,
  input  logic [WIDTH-1:0]    fifo_data [0:PORT_NUM-1],
  input  logic [PORT_NUM-1:0] fifo_data_valid,
  input  logic                fifo_empty,
  output logic [PORT_NUM-1:0] fifo_pop_valid,
  output logic                fifo_pop,
  output logic [WIDTH-1:0]    out_data,
  output logic                out_valid,
  input  logic                out_ready
);

  localparam int CNT_W = cnt_width(PORT_NUM);
  localparam int IDX_W = idx_width(PORT_NUM);

  multififo_reader_state_t state_q, state_d;
  logic [CNT_W-1:0]    count_q, count_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic [WIDTH-1:0]    stage_q [0:PORT_NUM-1];
  logic [WIDTH-1:0]    stage_d [0:PORT_NUM-1];
  logic                out_valid_q, out_valid_d;
  logic [WIDTH-1:0]    out_data_q, out_data_d;

  logic [CNT_W-1:0]    n_s;
  logic [PORT_NUM-1:0] mask_s;
  logic                load_s;
  logic                can_load_s;
  logic                last_s;

  count_one #(.WIDTH(PORT_NUM), .CONTINUOUS(1'b1)) u_count (
    .data  (fifo_data_valid),
    .count (n_s)
  );

  expand_one #(.WIDTH(PORT_NUM)) u_expand (
    .count (n_s),
    .mask  (mask_s)
  );

  // An empty leading run would stage nothing, so it is not treated as a load.
  assign can_load_s = !fifo_empty && (n_s != '0);
  assign last_s     = (CNT_W'(idx_q) == (count_q - CNT_W'(1)));

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    idx_d   = idx_q;
    stage_d = stage_q;
    load_s  = 1'b0;
    case (state_q)
      LOAD: begin
        if (can_load_s) begin
          load_s  = 1'b1;
          state_d = DRAIN;
        end else begin
          state_d = LOAD;
        end
      end
      DRAIN: begin
        if (out_ready && last_s) begin
`ifdef MULTIFIFO_READER_REFILL_EN
          if (can_load_s) begin
            load_s = 1'b1;
          end else begin
            state_d = LOAD;
          end
`else
          state_d = LOAD;
`endif
        end else if (out_ready) begin
          idx_d = idx_q + 1'b1;
        end else begin
          idx_d = idx_q;
        end
      end
      default: state_d = LOAD;
    endcase

    if (load_s) begin
      for (int k = 0; k < PORT_NUM; k++) begin
        if (mask_s[k]) begin
          stage_d[k] = fifo_data[k];
        end
      end
      count_d = n_s;
      idx_d   = '0;
    end

    // Flush overrides any load, acceptance or refill decided above.
    if (flush) begin
      load_s  = 1'b0;
      state_d = LOAD;
      count_d = '0;
      idx_d   = '0;
    end

    out_valid_d = (state_d == DRAIN);
    out_data_d  = stage_d[idx_d];
  end

  assign fifo_pop       = load_s && rst_n;
  assign fifo_pop_valid = (load_s && rst_n) ? mask_s : '0;
  assign out_valid      = out_valid_q;
  assign out_data       = out_data_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= LOAD;
      count_q     <= '0;
      idx_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int k = 0; k < PORT_NUM; k++) begin
        stage_q[k] <= '0;
      end
    end else begin
      state_q     <= state_d;
      count_q     <= count_d;
      idx_q       <= idx_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      stage_q     <= stage_d;
    end
  end

endmodule

// File: tb/tb_multififo_reader.sv
// Directed self-checking bench for multififo_reader with PORT_NUM=4, WIDTH=32.
// Expectations follow MULTIFIFO_READER_REFILL_EN when it is defined.
module tb_multififo_reader;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        flush;
  logic [31:0] fifo_data [0:3];
  logic [3:0]  fifo_data_valid;
  logic        fifo_empty;
  logic [3:0]  fifo_pop_valid;
  logic        fifo_pop;
  logic [31:0] out_data;
  logic        out_valid;
  logic        out_ready;

  int checks = 0;
  int failures = 0;

  multififo_reader #(.PORT_NUM(4), .WIDTH(32)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .flush           (flush),
    .fifo_data       (fifo_data),
    .fifo_data_valid (fifo_data_valid),
    .fifo_empty      (fifo_empty),
    .fifo_pop_valid  (fifo_pop_valid),
    .fifo_pop        (fifo_pop),
    .out_data        (out_data),
    .out_valid       (out_valid),
    .out_ready       (out_ready)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_data(input logic [31:0] base);
    for (int k = 0; k < 4; k++) fifo_data[k] = base + 32'(k);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; flush = 1'b0; out_ready = 1'b1;
    fifo_empty = 1'b0; fifo_data_valid = 4'b1111; set_data(32'hA0);
    #1;
    checks++; if (fifo_pop !== 1'b0) begin failures++; $display("FAIL reset_pop got=%b exp=0", fifo_pop); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", out_valid); end
    tick(); tick();
    checks++; if (fifo_pop !== 1'b0) begin failures++; $display("FAIL reset_pop_held got=%b exp=0", fifo_pop); end
    #2 rst_n = 1'b1;
    #1;
    checks++; if (fifo_pop !== 1'b1) begin failures++; $display("FAIL release_pop got=%b exp=1", fifo_pop); end
    checks++; if (fifo_pop_valid !== 4'b1111) begin failures++; $display("FAIL release_pop_valid got=%b exp=1111", fifo_pop_valid); end
  endtask

  task automatic test_full_batch();
    logic exp_pop;
    tick();                      // loads A0..A3
    set_data(32'hB0);
    for (int i = 0; i < 4; i++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hA0 + 32'(i)) begin
        failures++; $display("FAIL full_a%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 32'hA0 + 32'(i));
      end
`ifdef MULTIFIFO_READER_REFILL_EN
      exp_pop = (i == 3);
`else
      exp_pop = 1'b0;
`endif
      checks++; if (fifo_pop !== exp_pop) begin failures++; $display("FAIL full_pop%0d got=%b exp=%b", i, fifo_pop, exp_pop); end
      tick();
    end
`ifndef MULTIFIFO_READER_REFILL_EN
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_bubble got=%b exp=0", out_valid); end
    checks++; if (fifo_pop !== 1'b1) begin failures++; $display("FAIL full_bubble_pop got=%b exp=1", fifo_pop); end
    tick();
`endif
    fifo_empty = 1'b1;
    for (int i = 0; i < 4; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hB0 + 32'(i)) begin
        failures++; $display("FAIL full_b%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 32'hB0 + 32'(i));
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL full_idle got=%b exp=0", out_valid); end
  endtask

  task automatic test_partial();
    set_data(32'hC0); fifo_data_valid = 4'b1011; fifo_empty = 1'b0;
    #1;
    checks++; if (fifo_pop !== 1'b1 || fifo_pop_valid !== 4'b0011) begin
      failures++; $display("FAIL partial_pop got=%b/%b exp=1/0011", fifo_pop, fifo_pop_valid);
    end
    tick();
    fifo_empty = 1'b1; fifo_data_valid = 4'b1111;
    for (int i = 0; i < 2; i++) begin
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hC0 + 32'(i)) begin
        failures++; $display("FAIL partial_c%0d got=%b/%h exp=1/%h", i, out_valid, out_data, 32'hC0 + 32'(i));
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL partial_len got=%b exp=0", out_valid); end
  endtask

  task automatic test_backpressure();
    set_data(32'hD0); fifo_empty = 1'b0;
    tick();
    fifo_empty = 1'b1;
    checks++; if (out_data !== 32'hD0) begin failures++; $display("FAIL bp_d0 got=%h exp=d0", out_data); end
    tick();
    out_ready = 1'b0; fifo_empty = 1'b0;
    for (int c = 0; c < 5; c++) begin
      #1;
      checks++; if (out_valid !== 1'b1 || out_data !== 32'hD1 || fifo_pop !== 1'b0) begin
        failures++; $display("FAIL bp_stall%0d got=%b/%h/%b exp=1/d1/0", c, out_valid, out_data, fifo_pop);
      end
      tick();
    end
    out_ready = 1'b1; fifo_empty = 1'b1;
    for (int i = 1; i < 4; i++) begin
      checks++; if (out_data !== 32'hD0 + 32'(i)) begin
        failures++; $display("FAIL bp_d%0d got=%h exp=%h", i, out_data, 32'hD0 + 32'(i));
      end
      tick();
    end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL bp_end got=%b exp=0", out_valid); end
  endtask

  task automatic test_flush();
    set_data(32'hE0); fifo_empty = 1'b0;
    tick();
    fifo_empty = 1'b1;
    tick(); tick();
    checks++; if (out_data !== 32'hE2) begin failures++; $display("FAIL flush_e2 got=%h exp=e2", out_data); end
    flush = 1'b1; fifo_empty = 1'b0; set_data(32'hF0);
    #1;
    checks++; if (fifo_pop !== 1'b0) begin failures++; $display("FAIL flush_pop got=%b exp=0", fifo_pop); end
    tick();
    flush = 1'b0;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_valid got=%b exp=0", out_valid); end
    tick();
    fifo_empty = 1'b1;
    checks++; if (out_valid !== 1'b1 || out_data !== 32'hF0) begin
      failures++; $display("FAIL flush_reload got=%b/%h exp=1/f0", out_valid, out_data);
    end
    tick(); tick(); tick(); tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL flush_drain got=%b exp=0", out_valid); end
  endtask

  task automatic test_async_reset();
    set_data(32'h10); fifo_empty = 1'b0;
    tick();
    checks++; if (out_valid !== 1'b1 || out_data !== 32'h10) begin
      failures++; $display("FAIL arst_pre got=%b/%h exp=1/10", out_valid, out_data);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || fifo_pop !== 1'b0) begin
      failures++; $display("FAIL arst_now got=%b/%b exp=0/0", out_valid, fifo_pop);
    end
    tick();
    #2 rst_n = 1'b1; fifo_empty = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL arst_after got=%b exp=0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_full_batch();
    test_partial();
    test_backpressure();
    test_flush();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/multififo_reader.md
# multififo_reader

Read-side drain engine for the multi-port FIFO. It pops up to PORT_NUM entries per transaction from the FIFO's read port into a local staging buffer. It then presents them one per cycle, in order, on a single-lane valid/ready stream. It sits between a multi-port queue (for example the fetch/decode queue) and any single-issue consumer.

## Interface
- PORT_NUM, 2: FIFO read ports per cycle; power of two, ≥2
- WIDTH, 32: entry width in bits
- clk  in  1  clock
- rst_n  in  1  reset; one clock, asynchronous, active-low
- flush  in  1  synchronous flush; discards staged entries
- fifo_data  in  WIDTH×[0:PORT_NUM-1]  FIFO data_out lanes
- fifo_data_valid  in  PORT_NUM  FIFO data_out_valid; contiguous from lane 0
- fifo_empty  in  1  FIFO empty
- fifo_pop_valid  out  PORT_NUM  lanes being consumed; contiguous from lane 0
- fifo_pop  out  1  pop strobe to FIFO
- out_data  out  WIDTH  current entry
- out_valid  out  1  out_data valid
- out_ready  in  1  consumer accepts out_data

## Operation
- Storage:
  - staging buffer buf[0:PORT_NUM-1] of WIDTH bits
  - count, $clog2(PORT_NUM)+1 bits: valid staged entries
  - idx, $clog2(PORT_NUM) bits: next entry to emit
- Batch size n: number of leading ones of fifo_data_valid. Lanes above the first zero are ignored.
- Load: set fifo_pop=1 and fifo_pop_valid = fifo_data_valid restricted to the leading-ones run. In the same edge, capture buf[k]=fifo_data[k] for k<n, set count=n and idx=0.
- State LOAD:
  - out_valid=0
  - if !fifo_empty && !flush: load, then go to DRAIN
  - else: fifo_pop=0, fifo_pop_valid=0
- State DRAIN:
  - out_valid=1 and out_data=buf[idx]
  - on out_valid && out_ready: idx+1
  - when idx==count-1 is accepted, the batch is done; go to LOAD (or refill, see Configuration)
- fifo_pop is 0 in DRAIN unless the refill path is active.
- Flush:
  - state goes to LOAD, count=0, idx=0, no pop issued that cycle
  - flush wins over a simultaneous load, acceptance or refill
- Entries leave strictly in FIFO order; no entry is dropped or duplicated.
- Reset values: state=LOAD, count=0, idx=0, out_valid=0, fifo_pop=0, fifo_pop_valid=0. out_data is don't-care while out_valid=0.
- fifo_pop and fifo_pop_valid are forced 0 while rst_n=0.
- Reset asserted mid-batch discards staged entries immediately. Entries already popped are lost; the owner resets the FIFO together with this block.

## Timing
- fifo_pop and fifo_pop_valid are combinational from state, fifo_empty, fifo_data_valid, out_ready and flush.
- out_valid and out_data come from registers only.
- Load-to-output latency: 1 cycle. FIFO non-empty at edge T gives out_valid=1 after edge T+1.
- Stalls: out_valid stays 1 and out_data stays stable while out_ready=0.
- Throughput without the configurable refill: n entries per n+1 cycles.
- Index wrap: idx wraps modulo PORT_NUM. It never exceeds count-1 while in DRAIN.

## Configuration
- MULTIFIFO_READER_REFILL_EN defined:
  - in DRAIN, when the last entry is accepted and !fifo_empty && !flush, load a new batch in the same cycle and stay in DRAIN
  - result: 1 entry per cycle sustained, no bubble
- Undefined: the last acceptance always returns to LOAD, costing one bubble cycle per batch.

## Structure
- Shared package: state typedef multififo_reader_state_t {LOAD, DRAIN}.
- Shared package: count and idx width constants derived from PORT_NUM.
- The leading-ones count uses the existing count_one (CONTINUOUS=1) sub-module.
- Pop-mask generation uses expand_one.
- No new sub-module.

## Test plan
All scenarios use PORT_NUM=4, WIDTH=32.
- Reset:
  - hold rst_n=0 with fifo_empty=0 and fifo_data_valid=4'b1111
  - required: fifo_pop=0, out_valid=0
  - release: pop in first cycle with fifo_pop_valid=4'b1111
- Full batch:
  - lanes 0xA0..0xA3, out_ready=1
  - required: out_data 0xA0,0xA1,0xA2,0xA3 on consecutive cycles, then one bubble (macro off) or 0xB0 immediately (macro on, next batch 0xB0..)
- Partial and non-contiguous valid:
  - fifo_data_valid=4'b1011
  - required: fifo_pop_valid=4'b0011, only 2 entries emitted
- Backpressure:
  - out_ready=0 for 5 cycles mid-batch
  - required: out_data frozen, no fifo_pop, order preserved after release
- Flush:
  - flush asserted while idx=2 of a 4-entry batch
  - required: out_valid=0 next cycle, no pop in the flush cycle, next load starts with idx=0
- Async reset mid-DRAIN:
  - rst_n falls between edges
  - required: out_valid=0 immediately, without waiting for a clock edge
